// File: rtl/spram_resp_if.sv
// spram_resp_if: request/response bundle between an SPRAM client and the
// spram_resp responder. Signal names keep the responder's i_/o_ view so the
// same names read naturally on both sides of the link.
interface spram_resp_if #(
    parameter int ADDR_SZ = 14,
    parameter int DATA_SZ = 16
);
    logic               i_wr_en;
    logic [ADDR_SZ-1:0] i_waddr;
    logic [DATA_SZ-1:0] i_wdata;
    logic               o_wr_ready;
    logic               i_rd_en;
    logic [ADDR_SZ-1:0] i_raddr;
    logic [DATA_SZ-1:0] o_rdata;
    logic               o_rd_valid;
    logic [7:0]         o_collisions;

    // Client side: issues requests, consumes responses.
    modport master (
        output i_wr_en, i_waddr, i_wdata, i_rd_en, i_raddr,
        input  o_wr_ready, o_rdata, o_rd_valid, o_collisions
    );

    // Responder side.
    modport slave (
        input  i_wr_en, i_waddr, i_wdata, i_rd_en, i_raddr,
        output o_wr_ready, o_rdata, o_rd_valid, o_collisions
    );
endinterface

// File: rtl/spram_resp.sv
// spram_resp: single-ported storage serving independent read and write
// requests. A write that collides with a read is parked in a one-entry
// buffer and drained on the next read-free cycle; reads hitting the parked
// address are forwarded from the buffer.
// Optional feature macro: SPRAM_RESP_STATS_EN enables the saturating
// collision counter on o_collisions (otherwise it is tied to zero).
module spram_resp #(
    parameter int ADDR_SZ = 14,
    parameter int DATA_SZ = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    spram_resp_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DATA_SZ-1:0] mem_q [2**ADDR_SZ];
    logic [ADDR_SZ-1:0] buf_addr_q;
    logic [DATA_SZ-1:0] buf_data_q;
    logic [DATA_SZ-1:0] rdata_q;
    logic               rd_valid_q;

    // Per-cycle control decoded from state and requests.
    logic               mem_we;
    logic [ADDR_SZ-1:0] mem_waddr;
    logic [DATA_SZ-1:0] mem_wdata;
    logic               buf_ld;
    logic               fwd;

    // State register; reset drops any parked write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    // Next state: park on collision, drain when the port is free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (bus.i_wr_en && bus.i_rd_en) state_d = FULL;
            FULL:  if (!bus.i_rd_en)               state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output decode: who owns the array port this cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.i_waddr;
        mem_wdata = bus.i_wdata;
        buf_ld    = 1'b0;
        fwd       = 1'b0;
        case (state_q)
            EMPTY: begin
                if (bus.i_wr_en && bus.i_rd_en) buf_ld = 1'b1;
                else if (bus.i_wr_en)           mem_we = 1'b1;
            end
            FULL: begin
                // i_wr_en is ignored here; the client holds it until ready.
                if (!bus.i_rd_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = buf_addr_q;
                    mem_wdata = buf_data_q;
                end else begin
                    fwd = (bus.i_raddr == buf_addr_q);
                end
            end
            default: ;
        endcase
    end

    // Ready depends on state only, never on this cycle's inputs.
    assign bus.o_wr_ready = (state_q == EMPTY);

    // Storage array write port; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // Parked write entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else if (buf_ld) begin
            buf_addr_q <= bus.i_waddr;
            buf_data_q <= bus.i_wdata;
        end
    end

    // Registered read data; array read sees pre-write contents (read-before-write).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.i_rd_en;
            if (bus.i_rd_en) rdata_q <= fwd ? buf_data_q : mem_q[bus.i_raddr];
        end
    end

    assign bus.o_rdata    = rdata_q;
    assign bus.o_rd_valid = rd_valid_q;

`ifdef SPRAM_RESP_STATS_EN
    logic [7:0] coll_q, coll_d;

    // Saturating count of posted writes; cleared only by reset.
    always_comb begin
        coll_d = coll_q;
        if (buf_ld && coll_q != 8'hFF) coll_d = coll_q + 8'd1;
    end

    // Collision counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) coll_q <= 8'h00;
        else          coll_q <= coll_d;
    end

    assign bus.o_collisions = coll_q;
`else
    assign bus.o_collisions = 8'h00;
`endif
endmodule

// File: tb/tb_spram_resp.sv
// tb_spram_resp: directed vectors with hand-computed expectations for spram_resp.
module tb_spram_resp;
    localparam int AW = 14;
    localparam int DW = 16;
`ifdef SPRAM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_coll = 0;

    spram_resp_if #(.ADDR_SZ(AW), .DATA_SZ(DW)) bus ();

    spram_resp #(.ADDR_SZ(AW), .DATA_SZ(DW)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Apply one cycle of requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rd, input logic [AW-1:0] ra);
        bus.i_wr_en = wr;
        bus.i_waddr = wa;
        bus.i_wdata = wd;
        bus.i_rd_en = rd;
        bus.i_raddr = ra;
        @(posedge i_clk);
        #1;
        if (wr && rd && STATS && exp_coll < 255 && bus.o_wr_ready === 1'b0) exp_coll++;
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdata"}, 32'(bus.o_rdata), 32'h0);
        chk({tag, "_valid"}, 32'(bus.o_rd_valid), 32'h0);
        chk({tag, "_ready"}, 32'(bus.o_wr_ready), 32'h1);
        chk({tag, "_coll"},  32'(bus.o_collisions), 32'h0);
    endtask

    initial begin
        bus.i_wr_en = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0;
        bus.i_rd_en = 1'b0; bus.i_raddr = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset_vals("rst");
        i_rst_n = 1'b1;

        // Write only, then read back.
        cyc(1'b1, 14'h3FFF, 16'hBE11, 1'b0, '0);
        chk("w1_ready", 32'(bus.o_wr_ready), 32'h1);
        chk("w1_valid", 32'(bus.o_rd_valid), 32'h0);
        cyc(1'b1, 14'h0095, 16'hC0DE, 1'b0, '0);
        chk("w2_ready", 32'(bus.o_wr_ready), 32'h1);
        cyc(1'b0, '0, '0, 1'b1, 14'h3FFF);
        chk("r1_data",  32'(bus.o_rdata), 32'hBE11);
        chk("r1_valid", 32'(bus.o_rd_valid), 32'h1);
        chk("r1_ready", 32'(bus.o_wr_ready), 32'h1);
        cyc(1'b0, '0, '0, 1'b1, 14'h0095);
        chk("r2_data",  32'(bus.o_rdata), 32'hC0DE);
        chk("r2_valid", 32'(bus.o_rd_valid), 32'h1);
        idle();
        chk("idle_valid", 32'(bus.o_rd_valid), 32'h0);
        chk("idle_hold",  32'(bus.o_rdata), 32'hC0DE);

        // Collision, different address.
        cyc(1'b1, 14'h0010, 16'h1111, 1'b0, '0);
        cyc(1'b1, 14'h0020, 16'hFADE, 1'b1, 14'h0010);
        chk("c1_data",  32'(bus.o_rdata), 32'h1111);
        chk("c1_ready", 32'(bus.o_wr_ready), 32'h0);
        chk("c1_coll",  32'(bus.o_collisions), STATS ? 32'h1 : 32'h0);
        idle();
        chk("c1_drain", 32'(bus.o_wr_ready), 32'h1);
        cyc(1'b0, '0, '0, 1'b1, 14'h0020);
        chk("c1_rdback", 32'(bus.o_rdata), 32'hFADE);

        // Same-address collision: read-before-write, then forwarding, then array.
        cyc(1'b1, 14'h00FF, 16'hAAAA, 1'b0, '0);
        cyc(1'b1, 14'h00FF, 16'hDEAD, 1'b1, 14'h00FF);
        chk("c2_rbw",   32'(bus.o_rdata), 32'hAAAA);
        chk("c2_ready", 32'(bus.o_wr_ready), 32'h0);
        cyc(1'b0, '0, '0, 1'b1, 14'h00FF);
        chk("c2_fwd",   32'(bus.o_rdata), 32'hDEAD);
        chk("c2_full",  32'(bus.o_wr_ready), 32'h0);
        idle();
        chk("c2_drain", 32'(bus.o_wr_ready), 32'h1);
        cyc(1'b0, '0, '0, 1'b1, 14'h00FF);
        chk("c2_array", 32'(bus.o_rdata), 32'hDEAD);
        chk("c2_coll",  32'(bus.o_collisions), STATS ? 32'h2 : 32'h0);

        // Starvation: read stream holds FULL, held write does not land.
        cyc(1'b1, 14'h0300, 16'h0BAD, 1'b0, '0);
        cyc(1'b1, 14'h0200, 16'h1234, 1'b1, 14'h0010);
        chk("s_enter", 32'(bus.o_wr_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 14'h0300, 16'h7777, 1'b1, 14'h0300);
            chk($sformatf("s_ready%0d", i), 32'(bus.o_wr_ready), 32'h0);
            chk($sformatf("s_old%0d", i),   32'(bus.o_rdata), 32'h0BAD);
        end
        cyc(1'b1, 14'h0300, 16'h7777, 1'b0, '0);
        chk("s_drain", 32'(bus.o_wr_ready), 32'h1);
        cyc(1'b1, 14'h0300, 16'h7777, 1'b0, '0);
        chk("s_accept", 32'(bus.o_wr_ready), 32'h1);
        cyc(1'b0, '0, '0, 1'b1, 14'h0300);
        chk("s_held", 32'(bus.o_rdata), 32'h7777);
        cyc(1'b0, '0, '0, 1'b1, 14'h0200);
        chk("s_parked", 32'(bus.o_rdata), 32'h1234);
        chk("s_coll", 32'(bus.o_collisions), STATS ? 32'h3 : 32'h0);

        // Reset while FULL discards the parked write.
        cyc(1'b1, 14'h0001, 16'h0001, 1'b0, '0);
        cyc(1'b1, 14'h0001, 16'h5A5A, 1'b1, 14'h0002);
        chk("r_full", 32'(bus.o_wr_ready), 32'h0);
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
        i_rst_n = 1'b0;
        exp_coll = 0;
        #2;
        chk_reset_vals("mid_rst");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cyc(1'b0, '0, '0, 1'b1, 14'h0001);
        chk("r_discard", 32'(bus.o_rdata != 16'h5A5A), 32'h1);
        chk("r_valid",   32'(bus.o_rd_valid), 32'h1);

        // Collision counter saturation.
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 14'(16'h1000 + i), 16'(i), 1'b1, 14'h0000);
            idle();
            if (i == 9) chk("st_10", 32'(bus.o_collisions), STATS ? 32'd10 : 32'd0);
        end
        chk("st_sat", 32'(bus.o_collisions), STATS ? 32'hFF : 32'h00);
        chk("st_model", 32'(bus.o_collisions), 32'(exp_coll));
        cyc(1'b0, '0, '0, 1'b1, 14'h1005);
        chk("st_data", 32'(bus.o_rdata), 32'h0005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
